id_operand_bypass: RTL and testbench
====================================

Name: id_operand_bypass

Overview:
Parametrised decode-stage pipeline register with operand resolution. It sits between IF and EXE.
- Latches the instruction and PC from IF.
- Drives the regfile read addresses.
- Resolves rs/rt values through NUM_FWD downstream bypass sources, so no write-back wait is needed.
- Interlocks on producers whose data is not yet available (e.g. a load in EXE).
- Supports a flush from the branch/exception path.
- Replaces the always-ready decode handshake with a real ready_go.

Parameters:
DATA_W, 32, operand/data width
ADDR_W, 5, register index width
NUM_FWD, 3, number of bypass sources; index 0 = youngest (EXE), NUM_FWD-1 = oldest (WB)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
fs_to_ds_valid  in  1  IF holds a valid instruction
fs_inst  in  32  instruction from IF
fs_pc  in  DATA_W  PC from IF
ds_allowin  out  1  stage can accept this cycle
es_allowin  in  1  EXE can accept this cycle
flush  in  1  kill the instruction held in this stage
ds_to_es_valid  out  1  resolved instruction offered to EXE
ds_inst  out  32  latched instruction
ds_pc  out  DATA_W  latched PC
src1_used  in  1  external decoder: ds_inst reads rs
src2_used  in  1  external decoder: ds_inst reads rt
rf_raddr1  out  ADDR_W  = ds_inst[25:21]
rf_raddr2  out  ADDR_W  = ds_inst[20:16]
rf_rdata1  in  DATA_W  regfile port 1 data
rf_rdata2  in  DATA_W  regfile port 2 data
fwd_valid  in  NUM_FWD  source stage holds a valid instruction
fwd_we  in  NUM_FWD  source will write a GPR
fwd_dest  in  NUM_FWD*ADDR_W  source destination register, packed, index 0 at LSB
fwd_data  in  NUM_FWD*DATA_W  source result, packed
fwd_data_ok  in  NUM_FWD  fwd_data is final this cycle
rs_value  out  DATA_W  resolved rs operand
rt_value  out  DATA_W  resolved rt operand
ds_stall  out  1  interlock active

Behaviour:
Reset:
- resetn low clears ds_valid, ds_inst and ds_pc to 0 immediately, with no clock needed.
- The stall counter, if present, also clears to 0.
- While in reset, ds_to_es_valid=0 and ds_allowin=1.

Handshake:
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
- ds_to_es_valid = ds_valid & ds_ready_go & ~flush.
- ds_ready_go = ~ds_stall.

Pipeline register (posedge):
- If flush: ds_valid <= 0. Flush wins over any accept in the same cycle; the incoming fs instruction is dropped.
- Else if ds_allowin: ds_valid <= fs_to_ds_valid.
- ds_inst/ds_pc load only when fs_to_ds_valid & ds_allowin & ~flush; otherwise they hold.
- Latency IF->EXE is one cycle when there is no stall.

Operand resolution (combinational, per operand, using rs for src1 and rt for src2):
- A source i matches when fwd_valid[i] & fwd_we[i] & fwd_dest[i]==addr & addr!=0.
- The lowest matching index wins (youngest producer).
- The value is fwd_data of the winner; with no match, the value is rf_rdata.
- Register 0 always resolves to rf_rdata (0) and never stalls.

Stall:
- ds_stall = ds_valid & ((src1_used & winner1_exists & ~fwd_data_ok[winner1]) | (src2_used & winner2_exists & ~fwd_data_ok[winner2])).
- An older matching source with data_ok=1 does not mask a younger one that is not ready.
- While stalled, ds_inst/ds_pc hold and operands re-resolve every cycle.
- The stall releases in the cycle data_ok rises.

Boundaries:
- Both operands hit the same source: both take that source's data.
- rs==rt: identical results.
- Flush during a stall: ds_valid clears next edge and the stall drops.
- Unused operands never stall, even on a matching source that is not ready.

Optional Feature:
Macro: ID_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0], a wrapping counter that increments every cycle ds_stall=1, and holds otherwise.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package/header (mycpu.h): DATA_W/ADDR_W defaults, FWD_EXE=0/FWD_MEM=1/FWD_WB=2 index constants, and packed bus widths for the forwarding bus.
- Sub-module bypass_mux, instantiated twice (rs, rt):
  - inputs: addr, used, fwd vectors, rf_rdata
  - outputs: value, stall_req
  - implemented as a priority scan over NUM_FWD.

Test Plan:
1. Reset/accept: resetn=0 mid-stream -> ds_to_es_valid=0 immediately. After release, inst 0x24080005 at PC 0xBFC00000 with es_allowin=1 -> appears on ds_to_es_valid one cycle later.
2. Forward priority: rs=$8; src0 (dest 8, data 0x11) and src2 (dest 8, data 0x22) both ok -> rs_value=0x11. Src0 invalid -> 0x22. Neither -> rf_rdata1.
3. Load-use: src0 dest=$9, data_ok=0, rt=$9, src2_used=1 -> ds_stall=1, ds_allowin=0, inst held. data_ok=1 with data 0xDEADBEEF -> rt_value=0xDEADBEEF and the stage issues the same cycle.
4. $0 and unused: rs=$0 with src0 dest=0 not ok -> no stall, rs_value=0. rt match not ok with src2_used=0 -> no stall.
5. Flush: flush=1 while stalled with fs_to_ds_valid=1 -> ds_to_es_valid=0 that cycle, ds_valid=0 next cycle, new inst not latched.
6. ID_STALL_CNT_EN: 3-cycle stall, then 5 free cycles -> stall_cnt=3. Preload near 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/id_operand_bypass_pkg.sv
// Shared constants for the decode-stage operand bypass block.
//
// Holds the default data/register-index widths, the index assignment of the
// forwarding sources (EXE youngest at index 0, WB oldest), the instruction
// field positions of rs/rt and a helper that gives the width of a packed
// forwarding bus.
package id_operand_bypass_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int NUM_FWD_DEF = 3;
    localparam int INST_W      = 32;

    // Forwarding source indices; lower index = younger producer = higher priority
    localparam int FWD_EXE = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    // Register field positions inside the instruction word
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;

    // Width of a packed forwarding bus with n entries of w bits each
    function automatic int fwd_bus_w(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/id_operand_bypass_bypass_mux.sv
// bypass_mux: resolves one source operand against the forwarding sources.
//
// Ports:
//   addr         register index being read (rs or rt)
//   used         the current instruction actually reads this operand
//   fwd_valid    per source: stage holds a valid instruction
//   fwd_we       per source: instruction writes a GPR
//   fwd_dest     per source destination index, packed, index 0 at LSB
//   fwd_data     per source result, packed, index 0 at LSB
//   fwd_data_ok  per source: result is final this cycle
//   rf_rdata     register file value, used when nothing matches
//   value        resolved operand
//   stall_req    operand is needed but its youngest producer is not ready
module bypass_mux
    import id_operand_bypass_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic [ADDR_W-1:0]                     addr,
    input  logic                                  used,
    input  logic [NUM_FWD-1:0]                    fwd_valid,
    input  logic [NUM_FWD-1:0]                    fwd_we,
    input  logic [fwd_bus_w(NUM_FWD, ADDR_W)-1:0] fwd_dest,
    input  logic [fwd_bus_w(NUM_FWD, DATA_W)-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]                    fwd_data_ok,
    input  logic [DATA_W-1:0]                     rf_rdata,
    output logic [DATA_W-1:0]                     value,
    output logic                                  stall_req
);

    logic hit;
    logic hit_ok;

    // Scan from oldest to youngest so the lowest matching index is the last
    // assignment and therefore wins. Only the winner's data_ok matters: an
    // older ready producer must never hide a younger one that is not ready.
    always_comb begin
        value  = rf_rdata;
        hit    = 1'b0;
        hit_ok = 1'b1;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_we[i] && (addr != '0) &&
                (fwd_dest[i*ADDR_W +: ADDR_W] == addr)) begin
                value  = fwd_data[i*DATA_W +: DATA_W];
                hit    = 1'b1;
                hit_ok = fwd_data_ok[i];
            end
        end
    end

    assign stall_req = used & hit & ~hit_ok;

endmodule

// File: rtl/id_operand_bypass.sv
// id_operand_bypass: decode-stage pipeline register with operand resolution.
//
// Latches instruction/PC from IF, drives the register file read addresses,
// resolves rs/rt through NUM_FWD bypass sources (index 0 = EXE, youngest)
// and interlocks while a needed producer's data is not yet final.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   fs_to_ds_valid, fs_inst, fs_pc   instruction offered by IF
//   ds_allowin                       this stage can accept this cycle
//   es_allowin                       EXE can accept this cycle
//   flush                            kill the instruction held here
//   ds_to_es_valid, ds_inst, ds_pc   instruction offered to EXE
//   src1_used, src2_used             decoder: instruction reads rs / rt
//   rf_raddr1/2, rf_rdata1/2         register file read ports
//   fwd_valid/we/dest/data/data_ok   forwarding bus, index 0 at LSB
//   rs_value, rt_value               resolved operands
//   ds_stall                         interlock active
//   stall_cnt                        cycles spent stalled (only with ID_STALL_CNT_EN)
//
// Build option: define ID_STALL_CNT_EN to add the wrapping stall_cnt output.
module id_operand_bypass
    import id_operand_bypass_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  fs_to_ds_valid,
    input  logic [INST_W-1:0]                     fs_inst,
    input  logic [DATA_W-1:0]                     fs_pc,
    output logic                                  ds_allowin,
    input  logic                                  es_allowin,
    input  logic                                  flush,
    output logic                                  ds_to_es_valid,
    output logic [INST_W-1:0]                     ds_inst,
    output logic [DATA_W-1:0]                     ds_pc,
    input  logic                                  src1_used,
    input  logic                                  src2_used,
    output logic [ADDR_W-1:0]                     rf_raddr1,
    output logic [ADDR_W-1:0]                     rf_raddr2,
    input  logic [DATA_W-1:0]                     rf_rdata1,
    input  logic [DATA_W-1:0]                     rf_rdata2,
    input  logic [NUM_FWD-1:0]                    fwd_valid,
    input  logic [NUM_FWD-1:0]                    fwd_we,
    input  logic [fwd_bus_w(NUM_FWD, ADDR_W)-1:0] fwd_dest,
    input  logic [fwd_bus_w(NUM_FWD, DATA_W)-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]                    fwd_data_ok,
    output logic [DATA_W-1:0]                     rs_value,
    output logic [DATA_W-1:0]                     rt_value,
    output logic                                  ds_stall
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cnt
`endif
);

    logic ds_valid;
    logic ds_ready_go;
    logic stall_req1;
    logic stall_req2;
    logic accept;

    assign rf_raddr1 = ds_inst[RS_LSB +: ADDR_W];
    assign rf_raddr2 = ds_inst[RT_LSB +: ADDR_W];

    bypass_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD)
    ) u_rs_mux (
        .addr        (rf_raddr1),
        .used        (src1_used),
        .fwd_valid   (fwd_valid),
        .fwd_we      (fwd_we),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data),
        .fwd_data_ok (fwd_data_ok),
        .rf_rdata    (rf_rdata1),
        .value       (rs_value),
        .stall_req   (stall_req1)
    );

    bypass_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD)
    ) u_rt_mux (
        .addr        (rf_raddr2),
        .used        (src2_used),
        .fwd_valid   (fwd_valid),
        .fwd_we      (fwd_we),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data),
        .fwd_data_ok (fwd_data_ok),
        .rf_rdata    (rf_rdata2),
        .value       (rt_value),
        .stall_req   (stall_req2)
    );

    // An empty stage never interlocks, whatever the bypass bus shows.
    assign ds_stall       = ds_valid & (stall_req1 | stall_req2);
    assign ds_ready_go    = ~ds_stall;
    assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go & ~flush;

    // Flush beats accept: the instruction arriving in a flush cycle is dropped.
    assign accept = fs_to_ds_valid & ds_allowin & ~flush;

    // ---- IF -> ID pipeline register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_inst <= '0;
            ds_pc   <= '0;
        end else if (accept) begin
            ds_inst <= fs_inst;
            ds_pc   <= fs_pc;
        end
    end

`ifdef ID_STALL_CNT_EN
    // Free-running count of interlock cycles; wraps at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (ds_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_operand_bypass.sv
module tb_id_operand_bypass;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fs_to_ds_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        ds_allowin;
    logic        es_allowin;
    logic        flush;
    logic        ds_to_es_valid;
    logic [31:0] ds_inst;
    logic [31:0] ds_pc;
    logic        src1_used;
    logic        src2_used;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [2:0]  fwd_valid;
    logic [2:0]  fwd_we;
    logic [14:0] fwd_dest;
    logic [95:0] fwd_data;
    logic [2:0]  fwd_data_ok;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        ds_stall;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    // Bench-side view of the forwarding bus, one entry per source
    logic        b_valid [3];
    logic        b_we    [3];
    logic [4:0]  b_dest  [3];
    logic [31:0] b_data  [3];
    logic        b_ok    [3];

    assign fwd_valid   = {b_valid[2], b_valid[1], b_valid[0]};
    assign fwd_we      = {b_we[2], b_we[1], b_we[0]};
    assign fwd_dest    = {b_dest[2], b_dest[1], b_dest[0]};
    assign fwd_data    = {b_data[2], b_data[1], b_data[0]};
    assign fwd_data_ok = {b_ok[2], b_ok[1], b_ok[0]};

    id_operand_bypass dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_inst        (fs_inst),
        .fs_pc          (fs_pc),
        .ds_allowin     (ds_allowin),
        .es_allowin     (es_allowin),
        .flush          (flush),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_inst        (ds_inst),
        .ds_pc          (ds_pc),
        .src1_used      (src1_used),
        .src2_used      (src2_used),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .fwd_valid      (fwd_valid),
        .fwd_we         (fwd_we),
        .fwd_dest       (fwd_dest),
        .fwd_data       (fwd_data),
        .fwd_data_ok    (fwd_data_ok),
        .rs_value       (rs_value),
        .rt_value       (rt_value),
        .ds_stall       (ds_stall)
`ifdef ID_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the stage should be holding
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    // Expected outputs for the current inputs
    bit          e_stall, e_allowin, e_to_es;
    logic [31:0] e_rs, e_rt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Collect every source that matches; the youngest (first in the list) supplies the value.
    function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                    output logic [31:0] v, output bit not_ready);
        int hits[$];
        for (int i = 0; i < 3; i++)
            if (b_valid[i] && b_we[i] && b_dest[i] == a && a != 5'd0)
                hits.push_back(i);
        if (hits.size() == 0) begin
            v = rf;
            not_ready = 1'b0;
        end else begin
            v = b_data[hits[0]];
            not_ready = !b_ok[hits[0]];
        end
    endfunction

    task automatic compute_exp();
        bit n1, n2;
        logic [4:0] a1, a2;
        a1 = m_inst[25:21];
        a2 = m_inst[20:16];
        resolve(a1, rf_rdata1, e_rs, n1);
        resolve(a2, rf_rdata2, e_rt, n2);
        e_stall   = m_valid && ((src1_used && n1) || (src2_used && n2));
        e_allowin = !m_valid || (!e_stall && es_allowin);
        e_to_es   = m_valid && !e_stall && !flush;
    endtask

    task automatic check_all();
        compute_exp();
        check_eq("allowin",  ds_allowin, e_allowin);
        check_eq("to_es",    ds_to_es_valid, e_to_es);
        check_eq("stall",    ds_stall, e_stall);
        check_eq("inst",     ds_inst, m_inst);
        check_eq("pc",       ds_pc, m_pc);
        check_eq("raddr1",   rf_raddr1, m_inst[25:21]);
        check_eq("raddr2",   rf_raddr2, m_inst[20:16]);
        check_eq("rs_value", rs_value, e_rs);
        check_eq("rt_value", rt_value, e_rt);
`ifdef ID_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    // Advance one clock, applying the register rules to the reference state.
    task automatic tick();
        @(posedge clk);
        if (resetn) begin
            compute_exp();
            if (e_stall) m_cnt = m_cnt + 32'd1;
            if (fs_to_ds_valid && e_allowin && !flush) begin
                m_inst = fs_inst;
                m_pc   = fs_pc;
            end
            if (flush)          m_valid = 1'b0;
            else if (e_allowin) m_valid = fs_to_ds_valid;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_inst  = '0;
        m_pc    = '0;
        m_cnt   = '0;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 3; i++) begin
            b_valid[i] = 1'b0;
            b_we[i]    = 1'b0;
            b_dest[i]  = '0;
            b_data[i]  = '0;
            b_ok[i]    = 1'b0;
        end
    endtask

    task automatic set_src(input int i, input logic [4:0] dest, input logic [31:0] data, input logic ok);
        b_valid[i] = 1'b1;
        b_we[i]    = 1'b1;
        b_dest[i]  = dest;
        b_data[i]  = data;
        b_ok[i]    = ok;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1'b1;
        fs_inst        = inst;
        fs_pc          = pc;
    endtask

    initial begin
        logic [31:0] cnt0;
        resetn = 1'b0;
        fs_to_ds_valid = 1'b0;
        fs_inst = '0;
        fs_pc = '0;
        es_allowin = 1'b1;
        flush = 1'b0;
        src1_used = 1'b1;
        src2_used = 1'b1;
        rf_rdata1 = 32'hAAAA0001;
        rf_rdata2 = 32'hBBBB0002;
        clear_srcs();
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check_all();
        check_eq("rst_allowin", ds_allowin, 1'b1);
        check_eq("rst_to_es", ds_to_es_valid, 1'b0);
        resetn = 1'b1;

        // Asynchronous reset mid-stream
        offer(32'h01095020, 32'h00000100);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check_all();
        #1;
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_to_es", ds_to_es_valid, 1'b0);
        check_eq("async_rst_allowin", ds_allowin, 1'b1);
        check_eq("async_rst_inst", ds_inst, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Accept and issue one cycle later
        offer(32'h24080005, 32'hBFC00000);
        #1;
        check_all();
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check_all();
        check_eq("t1_issue", ds_to_es_valid, 1'b1);
        check_eq("t1_inst", ds_inst, 32'h24080005);
        check_eq("t1_pc", ds_pc, 32'hBFC00000);

        // Forward priority on rs=$8
        offer(32'h01095020, 32'h00000104);
        tick();
        fs_to_ds_valid = 1'b0;
        es_allowin = 1'b0;
        set_src(0, 5'd8, 32'h11, 1'b1);
        set_src(2, 5'd8, 32'h22, 1'b1);
        #1;
        check_all();
        check_eq("t2_youngest", rs_value, 32'h11);
        b_valid[0] = 1'b0;
        #1;
        check_all();
        check_eq("t2_oldest", rs_value, 32'h22);
        b_valid[2] = 1'b0;
        #1;
        check_all();
        check_eq("t2_regfile", rs_value, 32'hAAAA0001);

        // Load-use interlock on rt=$9
        es_allowin = 1'b1;
        clear_srcs();
        offer(32'h00095020, 32'h00000108);
        tick();
        offer(32'h12345678, 32'h0000010C);
        set_src(0, 5'd9, 32'h0, 1'b0);
        #1;
        check_all();
        check_eq("t3_stall", ds_stall, 1'b1);
        check_eq("t3_allowin", ds_allowin, 1'b0);
        tick();
        #1;
        check_all();
        check_eq("t3_hold", ds_inst, 32'h00095020);
        b_ok[0] = 1'b1;
        b_data[0] = 32'hDEADBEEF;
        #1;
        check_all();
        check_eq("t3_rt", rt_value, 32'hDEADBEEF);
        check_eq("t3_issue", ds_to_es_valid, 1'b1);
        check_eq("t3_release", ds_stall, 1'b0);
        tick();

        // Register 0 and unused operands never stall
        clear_srcs();
        offer(32'h00095020, 32'h00000110);
        tick();
        fs_to_ds_valid = 1'b0;
        rf_rdata1 = 32'h0;
        set_src(0, 5'd0, 32'h5555, 1'b0);
        #1;
        check_all();
        check_eq("t4_r0_stall", ds_stall, 1'b0);
        check_eq("t4_r0_value", rs_value, 32'h0);
        b_dest[0] = 5'd9;
        src2_used = 1'b0;
        #1;
        check_all();
        check_eq("t4_unused_stall", ds_stall, 1'b0);

        // Flush while stalled, with a new instruction offered
        src2_used = 1'b1;
        offer(32'hCAFE0000, 32'h00000300);
        flush = 1'b1;
        #1;
        check_all();
        check_eq("t5_stall", ds_stall, 1'b1);
        check_eq("t5_to_es", ds_to_es_valid, 1'b0);
        tick();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        #1;
        check_all();
        check_eq("t5_empty", ds_allowin, 1'b1);
        check_eq("t5_no_stall", ds_stall, 1'b0);
        check_eq("t5_not_latched", ds_inst, 32'h00095020);

`ifdef ID_STALL_CNT_EN
        // Three stalled cycles then five free ones
        clear_srcs();
        offer(32'h00095020, 32'h00000400);
        tick();
        fs_to_ds_valid = 1'b0;
        set_src(0, 5'd9, 32'h77, 1'b0);
        cnt0 = stall_cnt;
        for (int k = 0; k < 3; k++) tick();
        b_ok[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #1;
        check_eq("t6_cnt_delta", stall_cnt - cnt0, 32'd3);
`else
        cnt0 = '0;
`endif

        // Randomised traffic with addresses squeezed into $0..$3 to force matches
        for (int c = 0; c < 400; c++) begin
            fs_to_ds_valid = 1'($urandom);
            fs_inst = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            fs_pc = $urandom;
            es_allowin = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            src1_used = 1'($urandom);
            src2_used = 1'($urandom);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            for (int i = 0; i < 3; i++) begin
                b_valid[i] = 1'($urandom);
                b_we[i]    = 1'($urandom);
                b_dest[i]  = 5'($urandom_range(0, 3));
                b_data[i]  = $urandom;
                b_ok[i]    = ($urandom_range(0, 2) != 0);
            end
            #1;
            check_all();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
